// File: rtl/demo_clkctl.sv
// Board clock-control sequencer: qualifies DCM lock, sequences DCM and core
// resets, and produces per-channel divided clock-enable strobes while running.
module demo_clkctl #(
  parameter int NUM_CE      = 2,
  parameter int DIV_W       = 8,
  parameter int DCM_RST_CYC = 4,
  parameter int LOCK_FILT   = 16,
  parameter int RETRY_CYC   = 4096,
  parameter int RST_HOLD    = 32
) (
  input  logic                    CLK_IN,
  input  logic                    RST_N,
  input  logic                    LOCK_IN,
  input  logic [NUM_CE*DIV_W-1:0] DIV,
  output logic                    DCM_RST,
  output logic                    SYS_RST,
  output logic                    READY,
  output logic [NUM_CE-1:0]       CE,
  output logic [7:0]              RELOCK_CNT
);

  localparam int TMR_MAX_A = (DCM_RST_CYC > RETRY_CYC) ? DCM_RST_CYC : RETRY_CYC;
  localparam int TMR_MAX   = (TMR_MAX_A > RST_HOLD) ? TMR_MAX_A : RST_HOLD;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);
  localparam int FILT_W    = $clog2(LOCK_FILT + 1);

  typedef enum logic [1:0] {
    RESET_DCM = 2'd0,
    WAIT_LOCK = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [TMR_W-1:0]    tmr_reg, tmr_next;
  logic [FILT_W-1:0]   filt_reg, filt_next;
  logic [7:0]          relock_reg, relock_next;
  logic                sync1_reg, lock_s_reg;
  logic                dcm_rst_reg, sys_rst_reg, ready_reg;

  // Two-flop synchroniser for the asynchronous DCM LOCKED signal
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      sync1_reg  <= 1'b0;
      lock_s_reg <= 1'b0;
    end else begin
      sync1_reg  <= LOCK_IN;
      lock_s_reg <= sync1_reg;
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_reg   <= RESET_DCM;
      tmr_reg     <= '0;
      filt_reg    <= '0;
      relock_reg  <= 8'd0;
      dcm_rst_reg <= 1'b1;
      sys_rst_reg <= 1'b1;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tmr_reg     <= tmr_next;
      filt_reg    <= filt_next;
      relock_reg  <= relock_next;
      dcm_rst_reg <= (state_next == RESET_DCM);
      sys_rst_reg <= (state_next != RUN);
      ready_reg   <= (state_next == RUN);
    end
  end

  always_comb begin
    state_next  = state_reg;
    tmr_next    = tmr_reg + 1'b1;
    filt_next   = '0;
    relock_next = relock_reg;
    case (state_reg)
      RESET_DCM: begin
        if (tmr_reg == TMR_W'(DCM_RST_CYC - 1))
          state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s_reg)
          filt_next = (filt_reg == FILT_W'(LOCK_FILT)) ? filt_reg : filt_reg + 1'b1;
        // Timeout is checked first so it wins over a lock accepted in the same cycle
        if (tmr_reg == TMR_W'(RETRY_CYC - 1))
          state_next = RESET_DCM;
        else if (filt_reg == FILT_W'(LOCK_FILT))
          state_next = HOLD;
      end
      HOLD: begin
        if (!lock_s_reg)
          state_next = RESET_DCM;
        else if (tmr_reg == TMR_W'(RST_HOLD - 1))
          state_next = RUN;
      end
      RUN: begin
        tmr_next = '0;
        if (!lock_s_reg) begin
          state_next  = RESET_DCM;
          relock_next = (relock_reg == 8'hFF) ? relock_reg : relock_reg + 8'd1;
        end
      end
      default: state_next = RESET_DCM;
    endcase
    if (state_next != state_reg)
      tmr_next = '0;
    if (state_next != WAIT_LOCK)
      filt_next = '0;
  end

  assign DCM_RST    = dcm_rst_reg;
  assign SYS_RST    = sys_rst_reg;
  assign READY      = ready_reg;
  assign RELOCK_CNT = relock_reg;

  // Divide ratios are registered so CE depends only on flops; a ratio change
  // below the running count simply wraps the counter without a strobe.
  generate
    for (genvar gi = 0; gi < NUM_CE; gi++) begin : g_ce
      logic [DIV_W-1:0] div_reg;
      logic [DIV_W-1:0] cnt_reg;

      always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
          div_reg <= '0;
          cnt_reg <= '0;
        end else begin
          div_reg <= DIV[gi*DIV_W +: DIV_W];
          if (state_reg != RUN)
            cnt_reg <= '0;
          else if (cnt_reg >= div_reg)
            cnt_reg <= '0;
          else
            cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign CE[gi] = ready_reg & (cnt_reg == div_reg);
    end
  endgenerate

endmodule

// File: tb/tb_demo_clkctl.sv
// Directed bench for demo_clkctl: lock sequencing, CE division, lock loss,
// relock saturation, filter behaviour, async reset and retry timeout.
module tb_demo_clkctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, lock_in, rst_to_n, lock_to;
  logic [15:0] div, div_to;
  logic        dcm_rst, sys_rst, ready;
  logic [1:0]  ce;
  logic [7:0]  relock;
  logic        dcm_to, sys_to, ready_to;
  logic [1:0]  ce_to;
  logic [7:0]  relock_to;

  demo_clkctl dut (
    .CLK_IN(clk), .RST_N(rst_n), .LOCK_IN(lock_in), .DIV(div),
    .DCM_RST(dcm_rst), .SYS_RST(sys_rst), .READY(ready), .CE(ce), .RELOCK_CNT(relock)
  );

  demo_clkctl #(.RETRY_CYC(64)) dut_to (
    .CLK_IN(clk), .RST_N(rst_to_n), .LOCK_IN(lock_to), .DIV(div_to),
    .DCM_RST(dcm_to), .SYS_RST(sys_to), .READY(ready_to), .CE(ce_to), .RELOCK_CNT(relock_to)
  );

  int         n_checks = 0;
  int         n_err    = 0;
  logic [1:0] exp_q[$];
  logic       to_bad   = 1'b0;

  // While the timeout instance runs it must never release the core or count relocks
  always @(negedge clk)
    if (rst_to_n && (sys_to !== 1'b1 || relock_to !== 8'd0 || ready_to !== 1'b0))
      to_bad <= 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int         k;
    logic       prev_sys;
    logic [7:0] rc_exp;
    logic       seen_dcm, seen_ready;

    rst_n = 1'b0; rst_to_n = 1'b0; lock_in = 1'b0; lock_to = 1'b0;
    div = 16'h0; div_to = 16'h0;
    repeat (3) tick();

    check("rst_dcm",    32'(dcm_rst), 32'd1);
    check("rst_sys",    32'(sys_rst), 32'd1);
    check("rst_ready",  32'(ready),   32'd0);
    check("rst_ce",     32'(ce),      32'd0);
    check("rst_relock", 32'(relock),  32'd0);
    $display("step reset: dcm=%0d sys=%0d ready=%0d", dcm_rst, sys_rst, ready);

    // Clean lock
    rst_n = 1'b1;
    k = 0;
    while (dcm_rst && k < 20) begin tick(); k++; end
    check("dcm_rst_len", 32'(k), 32'd4);
    repeat (96) tick();
    div = {8'd0, 8'd3};
    lock_in = 1'b1;
    k = 0; prev_sys = sys_rst;
    while (!ready && k < 200) begin prev_sys = sys_rst; tick(); k++; end
    check("lock_to_ready", 32'(k), 32'd51);
    check("sys_rst_fall", 32'(sys_rst), 32'd0);
    check("sys_rst_before", 32'(prev_sys), 32'd1);
    $display("step clean lock: ready after %0d cycles", k);

    // CE divide: channel 0 ratio 3, channel 1 ratio 0
    for (int c = 1; c <= 16; c++) exp_q.push_back({1'b1, (c % 4 == 0)});
    for (int c = 0; c < 16; c++) begin
      check("ce_div3", 32'(ce), 32'(exp_q.pop_front()));
      tick();
    end
    $display("step ce divide 3/0 done");

    div = {8'd0, 8'd9};
    tick();
    k = 0;
    while (!ce[0] && k < 30) begin tick(); k++; end
    check("ce_div9_seen", 32'(ce[0]), 32'd1);
    repeat (5) tick();
    div = {8'd0, 8'd2};
    exp_q.push_back(2'b10);
    for (int j = 0; j < 12; j++) exp_q.push_back({1'b1, (j % 3 == 2)});
    for (int j = 0; j < 13; j++) begin
      tick();
      check("ce_div_change", 32'(ce), 32'(exp_q.pop_front()));
    end
    $display("step ce divide change 9->2 done");

    // Repeated lock loss and relock
    rc_exp = 8'd0;
    for (int i = 0; i < 300; i++) begin
      lock_in = 1'b0;
      tick(); tick();
      check("loss_n2_sys", 32'(sys_rst), 32'd0);
      tick();
      rc_exp = (rc_exp == 8'd255) ? 8'd255 : rc_exp + 8'd1;
      check("loss_sys",    32'(sys_rst), 32'd1);
      check("loss_ce",     32'(ce),      32'd0);
      check("loss_dcm",    32'(dcm_rst), 32'd1);
      check("loss_ready",  32'(ready),   32'd0);
      check("loss_relock", 32'(relock),  32'(rc_exp));
      lock_in = 1'b1;
      k = 0;
      while (!ready && k < 300) begin tick(); k++; end
      check("relock_time", 32'(k), 32'd53);
    end
    $display("step lock loss x300: relock=%0d", relock);

    // Lock filter: 10-high / 1-low never qualifies
    lock_in = 1'b0;
    repeat (12) tick();
    seen_dcm = 1'b0; seen_ready = 1'b0;
    for (int p = 0; p < 20; p++) begin
      lock_in = 1'b1;
      repeat (10) begin
        tick();
        seen_dcm |= dcm_rst; seen_ready |= ready;
      end
      lock_in = 1'b0;
      tick();
      seen_dcm |= dcm_rst; seen_ready |= ready;
    end
    check("filt_no_dcm",   32'(seen_dcm),   32'd0);
    check("filt_no_ready", 32'(seen_ready), 32'd0);
    lock_in = 1'b1;
    k = 0;
    while (!ready && k < 200) begin tick(); k++; end
    check("filt_steady_ready", 32'(k), 32'd51);
    $display("step lock filter: steady lock ready after %0d cycles", k);

    // Asynchronous reset while in HOLD
    lock_in = 1'b0;
    repeat (3) tick();
    lock_in = 1'b1;
    repeat (40) tick();
    check("hold_dcm",    32'(dcm_rst), 32'd0);
    check("hold_ready",  32'(ready),   32'd0);
    check("hold_relock", 32'(relock),  32'd255);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dcm",    32'(dcm_rst), 32'd1);
    check("arst_sys",    32'(sys_rst), 32'd1);
    check("arst_ready",  32'(ready),   32'd0);
    check("arst_ce",     32'(ce),      32'd0);
    check("arst_relock", 32'(relock),  32'd0);
    $display("step async reset in hold: relock=%0d", relock);
    tick();

    // Retry timeout with LOCK_IN held low
    rst_to_n = 1'b1;
    k = 0;
    while (dcm_to && k < 20) begin tick(); k++; end
    check("to_first_dcm", 32'(k), 32'd4);
    for (int p = 0; p < 3; p++) begin
      k = 0;
      while (!dcm_to && k < 200) begin tick(); k++; end
      check("to_wait_len", 32'(k), 32'd64);
      k = 0;
      while (dcm_to && k < 20) begin tick(); k++; end
      check("to_dcm_len", 32'(k), 32'd4);
      $display("step timeout period %0d done", p);
    end
    check("to_sys_relock", 32'(to_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
